bc_control_unit: RTL and testbench
==================================

// Module: bc_control_unit
// PURPOSE
//  Hardwired sequencer for the basic computer: timing counter T0..T6 plus instruction decode.
//  Drives the datapath's BUS_SEL and control-signal vector, consumes its IR/AC/DR/E state.
//  Implements fetch, indirect, memory-reference (AND ADD LDA STA BUN BSA ISZ), register-reference and HLT.
//  I=1 with opcode 7 (I/O) executes as a NOP.
// PARAMETERS
//  WIDTH   16  datapath word width
//  CTRL_W  23  control vector width: bits 0..19 single enables, bits 22:20 OPSEL_ALU
// PORTS
//  clk        in   1      system clock, rising edge; the block's only clock
//  RST        in   1      synchronous reset, active-high
//  IR_IN      in   WIDTH  instruction register: [15]=I, [14:12]=opcode, [11:0]=addr/reg-ref bits
//  AC_IN      in   WIDTH  accumulator, used by skip tests
//  DR_IN      in   WIDTH  data register, used by ISZ zero test
//  E_IN       in   1      E flip-flop, used by SZE (tie 0 if unconnected)
//  BUS_SEL    out  3      bus source: 0 AR, 1 PC, 2 DR, 3 AC, 4 IR, 5 TR, 6 MEM, 7 WRD
//  CTRL_SGNLS out  CTRL_W 0 LD_AR 1 INR_AR 2 CLR_AR 3 LD_PC 4 INR_PC 5 CLR_PC 6 LD_DR 7 INR_DR 8 CLR_DR
//                         9 LD_AC 10 INR_AC 11 CLR_AC 12 LD_IR 13 LD_TR 14 INR_TR 15 CLR_TR 16 MEM_WE
//                         17 LD_E 18 CMP_E 19 CLR_E 22:20 OPSEL_ALU
//  SC_OUT     out  3      current timing state (0=T0 .. 6=T6)
//  HALT       out  1      high after HLT until RST
// BEHAVIOUR
//  - State: 3-bit SC and a HALT flag, both registered. All outputs are combinational from SC, HALT, IR_IN,
//    AC_IN, DR_IN and E_IN. Signals asserted in Tn take effect at the clk edge that ends Tn.
//  - SC increments every cycle unless cleared; "SC<-0" means next state is T0. Every path clears by T6; no wrap.
//  - Memory read is combinational from AR, so MEM is valid on the bus in the cycle it is selected.
//    MEM_WE writes BUS to M[AR] at the edge.
//  - RST high: SC<-0, HALT<-0. Outputs during RST: CLR_AR/PC/DR/AC/TR/E=1, all others 0, BUS_SEL=0.
//    Reset mid-instruction abandons it; the first cycle after RST low is T0.
//  - Defaults when not listed below: all enables 0, BUS_SEL=0, OPSEL=OP_PASS.
//  - HALT=1: all enables 0, SC held at 0.
//  - Fetch:
//      T0  BUS=PC, LD_AR
//      T1  BUS=MEM, LD_IR, INR_PC
//      T2  BUS=IR, LD_AR (AR<-IR[11:0])
//  - T3:
//      D7 & ~I  register-reference (below), SC<-0
//      D7 & I   NOP, SC<-0
//      ~D7 & I  BUS=MEM, LD_AR (indirect)
//      ~D7 & ~I no action
//  - AND/ADD/LDA: T4 BUS=MEM, LD_DR; T5 LD_AC with OPSEL=OP_AND/OP_ADD/OP_PASS, SC<-0.
//    ADD also asserts LD_E (ALU carry-out into E).
//  - STA: T4 BUS=AC, MEM_WE, SC<-0.
//  - BUN: T4 BUS=AR, LD_PC, SC<-0.
//  - BSA: T4 BUS=PC, MEM_WE, INR_AR; T5 BUS=AR, LD_PC, SC<-0.
//  - ISZ: T4 BUS=MEM, LD_DR; T5 INR_DR; T6 BUS=DR, MEM_WE, SC<-0, and INR_PC iff DR_IN==0 (wrap FFFF->0000 skips).
//  - Register-reference: one op only, priority IR[11] highest down to IR[0]; IR[11:0]==0 is NOP.
//      11 CLA  CLR_AC
//      10 CLE  CLR_E
//       9 CMA  LD_AC, OP_CMA
//       8 CME  CMP_E
//       7 CIR  LD_AC, LD_E, OP_SHR
//       6 CIL  LD_AC, LD_E, OP_SHL
//       5 INC  INR_AC
//       4 SPA  INR_PC iff AC_IN[15]==0
//       3 SNA  INR_PC iff AC_IN[15]==1
//       2 SZA  INR_PC iff AC_IN==0
//       1 SZE  INR_PC iff E_IN==0
//       0 HLT  HALT<-1
// STRUCTURE
//  - Package bc_pkg:
//      BUS_SEL codes SEL_AR..SEL_WRD (0..7)
//      CTRL_SGNLS bit indices
//      OPSEL codes OP_AND=0 OP_ADD=1 OP_PASS=2 OP_CMA=3 OP_SHR=4 OP_SHL=5 (shared with ALU)
//      opcode constants
//  - Sub-module seq_counter: 3-bit counter with synchronous CLR (priority) and INC; holds SC.
// TESTING
//  - Reset: assert RST with SC=5 -> next cycle SC_OUT=0, HALT=0, CLR_* =1 during RST;
//    after release T0 shows BUS_SEL=1, LD_AR=1.
//  - LDA direct, IR=0x2010, M[0x010]=0x1234 -> T4 BUS_SEL=6 LD_DR; T5 LD_AC OPSEL=2; AC=0x1234; SC back to 0.
//  - ADD indirect, IR=0x9020, M[0x020]=0x0030, M[0x030]=5, AC=3 -> T3 LD_AR from MEM; AC=8 after T5; 6 cycles total.
//  - BSA, IR=0x5040, PC=0x011 -> M[0x040]=0x011, PC=0x041 after T5.
//  - ISZ, M[0x050]=0xFFFF -> M[0x050]=0x0000 and PC skips (+1) in T6;
//    with M[0x050]=0x0001, no skip and M=0x0002.
//  - Register-reference: IR=0x7004 (SZA), AC=0 -> INR_PC in T3. IR=0x7001 (HLT) -> HALT=1 and no enables
//    until RST. IR=0x7A00 -> only CLA acts (priority).

Source files
------------

// File: rtl/bc_pkg.sv
// Shared definitions for the basic-computer control unit and its datapath.
// Holds bus source codes, control-vector bit positions, ALU operation codes
// (shared with the ALU) and the memory-reference opcode values.
package bc_pkg;

  // Bus source select codes
  localparam logic [2:0] SEL_AR  = 3'd0;
  localparam logic [2:0] SEL_PC  = 3'd1;
  localparam logic [2:0] SEL_DR  = 3'd2;
  localparam logic [2:0] SEL_AC  = 3'd3;
  localparam logic [2:0] SEL_IR  = 3'd4;
  localparam logic [2:0] SEL_TR  = 3'd5;
  localparam logic [2:0] SEL_MEM = 3'd6;
  localparam logic [2:0] SEL_WRD = 3'd7;

  // Control vector bit positions
  localparam int LD_AR     = 0;
  localparam int INR_AR    = 1;
  localparam int CLR_AR    = 2;
  localparam int LD_PC     = 3;
  localparam int INR_PC    = 4;
  localparam int CLR_PC    = 5;
  localparam int LD_DR     = 6;
  localparam int INR_DR    = 7;
  localparam int CLR_DR    = 8;
  localparam int LD_AC     = 9;
  localparam int INR_AC    = 10;
  localparam int CLR_AC    = 11;
  localparam int LD_IR     = 12;
  localparam int LD_TR     = 13;
  localparam int INR_TR    = 14;
  localparam int CLR_TR    = 15;
  localparam int MEM_WE    = 16;
  localparam int LD_E      = 17;
  localparam int CMP_E     = 18;
  localparam int CLR_E     = 19;
  localparam int OPSEL_LSB = 20;

  // ALU operation codes
  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_PASS = 3'd2;
  localparam logic [2:0] OP_CMA  = 3'd3;
  localparam logic [2:0] OP_SHR  = 3'd4;
  localparam logic [2:0] OP_SHL  = 3'd5;

  // Instruction opcodes (IR[14:12])
  typedef enum logic [2:0] {
    OPC_AND = 3'd0,
    OPC_ADD = 3'd1,
    OPC_LDA = 3'd2,
    OPC_STA = 3'd3,
    OPC_BUN = 3'd4,
    OPC_BSA = 3'd5,
    OPC_ISZ = 3'd6,
    OPC_D7  = 3'd7
  } opcode_e;

endpackage

// File: rtl/bc_control_unit_seq_counter.sv
// Sequence counter holding the timing state T0..T6.
// Ports:
//   clk    rising-edge clock
//   clr_i  synchronous clear to 0 (wins over inc_i)
//   inc_i  increment
//   sc_o   current count
module seq_counter (
  input  logic       clk,
  input  logic       clr_i,
  input  logic       inc_i,
  output logic [2:0] sc_o
);

  logic [2:0] sc_q;
  logic [2:0] sc_d;

  always_comb begin
    sc_d = sc_q;
    if (clr_i)      sc_d = 3'd0;
    else if (inc_i) sc_d = sc_q + 3'd1;
  end

  always_ff @(posedge clk) begin
    sc_q <= sc_d;
  end

  assign sc_o = sc_q;

endmodule

// File: rtl/bc_control_unit.sv
// Hardwired sequencer for the basic computer: timing counter plus instruction
// decode. Produces the bus source select and control vector for the datapath.
// Ports:
//   clk         rising-edge clock
//   RST         synchronous active-high reset
//   IR_IN       instruction register ([15]=I, [14:12]=opcode, [11:0]=addr/reg bits)
//   AC_IN       accumulator (skip tests)
//   DR_IN       data register (ISZ zero test)
//   E_IN        E flip-flop (SZE)
//   BUS_SEL     bus source select
//   CTRL_SGNLS  control vector; [22:20] carries the ALU operation
//   SC_OUT      current timing state
//   HALT        set by HLT, cleared by RST
module bc_control_unit
  import bc_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int CTRL_W = 23
) (
  input  logic              clk,
  input  logic              RST,
  input  logic [WIDTH-1:0]  IR_IN,
  input  logic [WIDTH-1:0]  AC_IN,
  input  logic [WIDTH-1:0]  DR_IN,
  input  logic              E_IN,
  output logic [2:0]        BUS_SEL,
  output logic [CTRL_W-1:0] CTRL_SGNLS,
  output logic [2:0]        SC_OUT,
  output logic              HALT
);

  logic [2:0]        sc;
  logic              sc_clr;
  logic              halt_q;
  logic              halt_d;
  logic [CTRL_W-1:0] ctrl;
  logic [2:0]        bus_sel;
  logic [2:0]        opsel;

  logic    ind;
  opcode_e opc;
  logic    d7;

  assign ind = IR_IN[15];
  assign opc = opcode_e'(IR_IN[14:12]);
  assign d7  = (opc == OPC_D7);

  seq_counter u_sc (
    .clk   (clk),
    .clr_i (sc_clr),
    .inc_i (~sc_clr),
    .sc_o  (sc)
  );

  always_comb begin
    ctrl    = '0;
    bus_sel = SEL_AR;
    opsel   = OP_PASS;
    sc_clr  = 1'b0;
    halt_d  = halt_q;
    if (RST) begin
      ctrl[CLR_AR] = 1'b1;
      ctrl[CLR_PC] = 1'b1;
      ctrl[CLR_DR] = 1'b1;
      ctrl[CLR_AC] = 1'b1;
      ctrl[CLR_TR] = 1'b1;
      ctrl[CLR_E]  = 1'b1;
      opsel        = 3'd0;
      sc_clr       = 1'b1;
      halt_d       = 1'b0;
    end else if (halt_q) begin
      sc_clr = 1'b1;
    end else begin
      case (sc)
        3'd0: begin
          bus_sel      = SEL_PC;
          ctrl[LD_AR]  = 1'b1;
        end
        3'd1: begin
          bus_sel      = SEL_MEM;
          ctrl[LD_IR]  = 1'b1;
          ctrl[INR_PC] = 1'b1;
        end
        3'd2: begin
          bus_sel      = SEL_IR;
          ctrl[LD_AR]  = 1'b1;
        end
        3'd3: begin
          if (d7) begin
            sc_clr = 1'b1;
            // Register-reference: only the highest set bit acts; I=1 here is a NOP.
            if (!ind) begin
              if (IR_IN[11])      ctrl[CLR_AC] = 1'b1;
              else if (IR_IN[10]) ctrl[CLR_E]  = 1'b1;
              else if (IR_IN[9]) begin
                ctrl[LD_AC] = 1'b1;
                opsel       = OP_CMA;
              end
              else if (IR_IN[8])  ctrl[CMP_E]  = 1'b1;
              else if (IR_IN[7]) begin
                ctrl[LD_AC] = 1'b1;
                ctrl[LD_E]  = 1'b1;
                opsel       = OP_SHR;
              end
              else if (IR_IN[6]) begin
                ctrl[LD_AC] = 1'b1;
                ctrl[LD_E]  = 1'b1;
                opsel       = OP_SHL;
              end
              else if (IR_IN[5])  ctrl[INR_AC] = 1'b1;
              else if (IR_IN[4])  ctrl[INR_PC] = ~AC_IN[WIDTH-1];
              else if (IR_IN[3])  ctrl[INR_PC] = AC_IN[WIDTH-1];
              else if (IR_IN[2])  ctrl[INR_PC] = (AC_IN == '0);
              else if (IR_IN[1])  ctrl[INR_PC] = ~E_IN;
              else if (IR_IN[0])  halt_d       = 1'b1;
            end
          end else if (ind) begin
            bus_sel     = SEL_MEM;
            ctrl[LD_AR] = 1'b1;
          end
        end
        3'd4: begin
          case (opc)
            OPC_AND, OPC_ADD, OPC_LDA, OPC_ISZ: begin
              bus_sel     = SEL_MEM;
              ctrl[LD_DR] = 1'b1;
            end
            OPC_STA: begin
              bus_sel      = SEL_AC;
              ctrl[MEM_WE] = 1'b1;
              sc_clr       = 1'b1;
            end
            OPC_BUN: begin
              bus_sel     = SEL_AR;
              ctrl[LD_PC] = 1'b1;
              sc_clr      = 1'b1;
            end
            OPC_BSA: begin
              bus_sel      = SEL_PC;
              ctrl[MEM_WE] = 1'b1;
              ctrl[INR_AR] = 1'b1;
            end
            default: sc_clr = 1'b1;
          endcase
        end
        3'd5: begin
          case (opc)
            OPC_AND: begin
              ctrl[LD_AC] = 1'b1;
              opsel       = OP_AND;
              sc_clr      = 1'b1;
            end
            OPC_ADD: begin
              // Carry-out of the add lands in E.
              ctrl[LD_AC] = 1'b1;
              ctrl[LD_E]  = 1'b1;
              opsel       = OP_ADD;
              sc_clr      = 1'b1;
            end
            OPC_LDA: begin
              ctrl[LD_AC] = 1'b1;
              opsel       = OP_PASS;
              sc_clr      = 1'b1;
            end
            OPC_BSA: begin
              bus_sel     = SEL_AR;
              ctrl[LD_PC] = 1'b1;
              sc_clr      = 1'b1;
            end
            OPC_ISZ: ctrl[INR_DR] = 1'b1;
            default: sc_clr = 1'b1;
          endcase
        end
        default: begin
          // T6 only follows ISZ; DR_IN already holds the incremented word here.
          sc_clr = 1'b1;
          if (opc == OPC_ISZ) begin
            bus_sel      = SEL_DR;
            ctrl[MEM_WE] = 1'b1;
            ctrl[INR_PC] = (DR_IN == '0);
          end
        end
      endcase
    end
    ctrl[OPSEL_LSB +: 3] = opsel;
  end

  always_ff @(posedge clk) begin
    halt_q <= halt_d;
  end

  assign BUS_SEL    = bus_sel;
  assign CTRL_SGNLS = ctrl;
  assign SC_OUT     = sc;
  assign HALT       = halt_q;

endmodule

// File: tb/tb_bc_control_unit.sv
module tb_bc_control_unit;
  import bc_pkg::*;

  logic        clk;
  logic        RST;
  logic [15:0] IR_IN, AC_IN, DR_IN;
  logic        E_IN;
  logic [2:0]  BUS_SEL;
  logic [22:0] CTRL_SGNLS;
  logic [2:0]  SC_OUT;
  logic        HALT;

  bc_control_unit #(.WIDTH(16), .CTRL_W(23)) dut (
    .clk        (clk),
    .RST        (RST),
    .IR_IN      (IR_IN),
    .AC_IN      (AC_IN),
    .DR_IN      (DR_IN),
    .E_IN       (E_IN),
    .BUS_SEL    (BUS_SEL),
    .CTRL_SGNLS (CTRL_SGNLS),
    .SC_OUT     (SC_OUT),
    .HALT       (HALT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model driven by the control outputs
  logic [11:0] ar, pc;
  logic [15:0] dr, ac, ir, tr;
  logic        e;
  logic [15:0] mem  [0:255];
  logic [15:0] prog [0:255];
  logic [15:0] bus;
  logic [16:0] alu;

  assign IR_IN = ir;
  assign AC_IN = ac;
  assign DR_IN = dr;
  assign E_IN  = e;

  always_comb begin
    case (BUS_SEL)
      SEL_AR:  bus = {4'h0, ar};
      SEL_PC:  bus = {4'h0, pc};
      SEL_DR:  bus = dr;
      SEL_AC:  bus = ac;
      SEL_IR:  bus = ir;
      SEL_TR:  bus = tr;
      SEL_MEM: bus = mem[ar[7:0]];
      default: bus = 16'h0000;
    endcase
  end

  always_comb begin
    alu = {e, dr};
    case (CTRL_SGNLS[22:20])
      OP_AND:  alu = {e, ac & dr};
      OP_ADD:  alu = {1'b0, ac} + {1'b0, dr};
      OP_CMA:  alu = {e, ~ac};
      OP_SHR:  alu = {ac[0], e, ac[15:1]};
      OP_SHL:  alu = {ac[15], ac[14:0], e};
      default: alu = {e, dr};
    endcase
  end

  always @(posedge clk) begin
    if (RST) for (int i = 0; i < 256; i++) mem[i] <= prog[i];
    else if (CTRL_SGNLS[MEM_WE]) mem[ar[7:0]] <= bus;
    if (CTRL_SGNLS[CLR_AR]) ar <= '0;
    else if (CTRL_SGNLS[LD_AR]) ar <= bus[11:0];
    else if (CTRL_SGNLS[INR_AR]) ar <= ar + 12'd1;
    if (CTRL_SGNLS[CLR_PC]) pc <= '0;
    else if (CTRL_SGNLS[LD_PC]) pc <= bus[11:0];
    else if (CTRL_SGNLS[INR_PC]) pc <= pc + 12'd1;
    if (CTRL_SGNLS[CLR_DR]) dr <= '0;
    else if (CTRL_SGNLS[LD_DR]) dr <= bus;
    else if (CTRL_SGNLS[INR_DR]) dr <= dr + 16'd1;
    if (CTRL_SGNLS[CLR_AC]) ac <= '0;
    else if (CTRL_SGNLS[LD_AC]) ac <= alu[15:0];
    else if (CTRL_SGNLS[INR_AC]) ac <= ac + 16'd1;
    if (CTRL_SGNLS[LD_IR]) ir <= bus;
    if (CTRL_SGNLS[CLR_TR]) tr <= '0;
    else if (CTRL_SGNLS[LD_TR]) tr <= bus;
    else if (CTRL_SGNLS[INR_TR]) tr <= tr + 16'd1;
    if (CTRL_SGNLS[CLR_E]) e <= 1'b0;
    else if (CTRL_SGNLS[LD_E]) e <= alu[16];
    else if (CTRL_SGNLS[CMP_E]) e <= ~e;
  end

  // Checking infrastructure
  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sbq[$];

  logic [2:0]  bs_log [0:7];
  logic [22:0] ct_log [0:7];

  localparam logic [22:0] CLR_MASK = 23'((1 << CLR_AR) | (1 << CLR_PC) | (1 << CLR_DR) |
                                         (1 << CLR_AC) | (1 << CLR_TR) | (1 << CLR_E));
  localparam logic [22:0] IDLE     = 23'({OP_PASS, 20'h00000});
  localparam logic [22:0] CLA_ONLY = 23'({OP_PASS, 20'h00000} | (1 << CLR_AC));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t x;
    x.tag = tag;
    x.exp = v;
    sbq.push_back(x);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    exp_t x;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_empty: observed %h expected queued value", obs);
    end else begin
      x = sbq.pop_front();
      chk(x.tag, obs, x.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from T0 until SC returns to 0, logging outputs per state.
  task automatic run_instr(output int n);
    n = 0;
    do begin
      bs_log[SC_OUT] = BUS_SEL;
      ct_log[SC_OUT] = CTRL_SGNLS;
      step();
      n++;
    end while (SC_OUT != 3'd0 && n < 12);
    checks++;
    assert (n < 12) else begin
      errors++;
      $error("FAIL run_timeout: observed %0d cycles expected fewer than 12", n);
    end
  endtask

  int n;

  initial begin
    for (int i = 0; i < 256; i++) prog[i] = 16'h0000;
    prog[8'h00] = 16'h2010;  // LDA 010
    prog[8'h01] = 16'h2011;  // LDA 011
    prog[8'h02] = 16'h9020;  // ADD I 020
    prog[8'h03] = 16'h2012;  // LDA 012
    prog[8'h04] = 16'h3010;  // STA 010
    prog[8'h05] = 16'h4010;  // BUN 010
    prog[8'h10] = 16'h1234;
    prog[8'h11] = 16'h0003;
    prog[8'h12] = 16'h5040;  // becomes BSA 040 at 010
    prog[8'h20] = 16'h0030;
    prog[8'h30] = 16'h0005;
    prog[8'h41] = 16'h6050;  // ISZ 050
    prog[8'h42] = 16'h7001;  // HLT (skipped)
    prog[8'h43] = 16'h6051;  // ISZ 051
    prog[8'h44] = 16'h7100;  // CME
    prog[8'h45] = 16'h7800;  // CLA
    prog[8'h46] = 16'h7004;  // SZA
    prog[8'h47] = 16'h7001;  // HLT (skipped)
    prog[8'h48] = 16'h7020;  // INC
    prog[8'h49] = 16'h7A00;  // CLA+CLE bits, CLA wins
    prog[8'h4A] = 16'h7001;  // HLT
    prog[8'h50] = 16'hFFFF;
    prog[8'h51] = 16'h0001;

    RST = 1'b1;
    step();
    step();
    chk("rst_ctrl", 32'(CTRL_SGNLS), 32'(CLR_MASK));
    chk("rst_bus", 32'(BUS_SEL), 32'd0);
    chk("rst_sc", 32'(SC_OUT), 32'd0);
    chk("rst_halt", 32'(HALT), 32'd0);
    RST = 1'b0;
    #1;
    chk("t0_bus", 32'(BUS_SEL), 32'(SEL_PC));
    chk("t0_ld_ar", 32'(CTRL_SGNLS[LD_AR]), 32'd1);

    // LDA 010
    push("lda_ac", 32'h1234);
    run_instr(n);
    chk("lda_t4_bus", 32'(bs_log[4]), 32'(SEL_MEM));
    chk("lda_t4_lddr", 32'(ct_log[4][LD_DR]), 32'd1);
    chk("lda_t5_ldac", 32'(ct_log[5][LD_AC]), 32'd1);
    chk("lda_t5_opsel", 32'(ct_log[5][22:20]), 32'(OP_PASS));
    chk("lda_cycles", 32'(n), 32'd6);
    sb_check(32'(ac));

    // Reset in the middle of the next LDA at T5
    n = 0;
    while (SC_OUT != 3'd5 && n < 12) begin
      step();
      n++;
    end
    chk("mid_sc5", 32'(SC_OUT), 32'd5);
    RST = 1'b1;
    #1;
    chk("mid_rst_ctrl", 32'(CTRL_SGNLS), 32'(CLR_MASK));
    step();
    chk("mid_rst_sc", 32'(SC_OUT), 32'd0);
    chk("mid_rst_halt", 32'(HALT), 32'd0);
    RST = 1'b0;
    #1;
    chk("mid_t0_bus", 32'(BUS_SEL), 32'(SEL_PC));
    chk("mid_pc", 32'(pc), 32'h000);

    // Program restarts from 0
    run_instr(n);
    push("lda2_ac", 32'h0003);
    run_instr(n);
    sb_check(32'(ac));

    // ADD I 020: AC=3 + M[M[020]]=5
    push("add_ac", 32'h0008);
    run_instr(n);
    chk("add_cycles", 32'(n), 32'd6);
    chk("add_t3_bus", 32'(bs_log[3]), 32'(SEL_MEM));
    chk("add_t3_ldar", 32'(ct_log[3][LD_AR]), 32'd1);
    chk("add_t5_lde", 32'(ct_log[5][LD_E]), 32'd1);
    chk("add_t5_opsel", 32'(ct_log[5][22:20]), 32'(OP_ADD));
    sb_check(32'(ac));

    // LDA 012 then STA 010
    run_instr(n);
    push("sta_mem", 32'h5040);
    run_instr(n);
    chk("sta_cycles", 32'(n), 32'd5);
    sb_check(32'(mem[8'h10]));

    // BUN 010
    push("bun_pc", 32'h010);
    run_instr(n);
    sb_check(32'(pc));

    // BSA 040 from 010 (PC=011 after fetch)
    push("bsa_mem", 32'h0011);
    push("bsa_pc", 32'h041);
    run_instr(n);
    chk("bsa_cycles", 32'(n), 32'd6);
    sb_check(32'(mem[8'h40]));
    sb_check(32'(pc));

    // ISZ wrapping FFFF -> 0000 skips
    push("isz1_mem", 32'h0000);
    push("isz1_pc", 32'h043);
    run_instr(n);
    chk("isz1_cycles", 32'(n), 32'd7);
    chk("isz1_t6_inr", 32'(ct_log[6][INR_PC]), 32'd1);
    sb_check(32'(mem[8'h50]));
    sb_check(32'(pc));

    // ISZ 0001 -> 0002 no skip
    push("isz2_mem", 32'h0002);
    push("isz2_pc", 32'h044);
    run_instr(n);
    chk("isz2_t6_inr", 32'(ct_log[6][INR_PC]), 32'd0);
    sb_check(32'(mem[8'h51]));
    sb_check(32'(pc));

    // CME, CLA
    run_instr(n);
    chk("cme_e", 32'(e), 32'd1);
    run_instr(n);
    chk("cla_ac", 32'(ac), 32'h0000);

    // SZA with AC=0 skips
    push("sza_pc", 32'h048);
    run_instr(n);
    chk("sza_t3_inr", 32'(ct_log[3][INR_PC]), 32'd1);
    chk("sza_cycles", 32'(n), 32'd4);
    sb_check(32'(pc));

    // INC then 7A00 (only CLA acts, E stays 1)
    run_instr(n);
    chk("inc_ac", 32'(ac), 32'h0001);
    run_instr(n);
    chk("prio_ctrl", 32'(ct_log[3]), 32'(CLA_ONLY));
    chk("prio_ac", 32'(ac), 32'h0000);
    chk("prio_e", 32'(e), 32'd1);

    // HLT
    run_instr(n);
    chk("hlt_flag", 32'(HALT), 32'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("hlt_ctrl", 32'(CTRL_SGNLS), 32'(IDLE));
      chk("hlt_sc", 32'(SC_OUT), 32'd0);
      chk("hlt_hold", 32'(HALT), 32'd1);
    end
    chk("hlt_pc", 32'(pc), 32'h04B);

    RST = 1'b1;
    step();
    RST = 1'b0;
    #1;
    chk("hlt_rst", 32'(HALT), 32'd0);
    chk("hlt_rst_bus", 32'(BUS_SEL), 32'(SEL_PC));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
